// File: rtl/clk_div_prog_if.sv
// Control and status bundle for clk_div_prog: enables, divisor load handshake,
// and the divided-clock / tick outputs.
interface clk_div_prog_if #(
  parameter int unsigned CNT_W = 16
);
  logic             en;
  logic             resync;
  logic [CNT_W-1:0] div_in;
  logic             div_req;
  logic             div_ack;
  logic [CNT_W-1:0] div_cur;
  logic             div_clk;
  logic             tick;
  logic             tick_fall;

  modport master (
    output en, resync, div_in, div_req,
    input  div_ack, div_cur, div_clk, tick, tick_fall
  );

  modport slave (
    input  en, resync, div_in, div_req,
    output div_ack, div_cur, div_clk, tick, tick_fall
  );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable clock divider: registered divided-clock level plus rise/fall
// tick enables, with a divisor shadow that is applied only at period starts.
module clk_div_prog #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DIV_RESET = 4
) (
  input logic           clk,
  input logic           rst,
  clk_div_prog_if.slave bus
);

  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] d, d_n;
  logic [CNT_W-1:0] shadow, shadow_n;
  logic [CNT_W-1:0] half, cnt_inc, req_div;
  logic             pending, pend_n;
  logic             clk_q, clk_n;
  logic             tick_q, tick_n;
  logic             fall_q, fall_n;
  logic             ack_q, ack_n;
  logic             restart;

  assign half    = d >> 1;
  assign cnt_inc = cnt + CNT_W'(1);
  assign restart = bus.resync | (bus.en & (cnt == d - CNT_W'(1)));
  assign req_div = (bus.div_in < CNT_W'(2)) ? CNT_W'(2) : bus.div_in;

  always_comb begin
    cnt_n    = cnt;
    d_n      = d;
    shadow_n = shadow;
    pend_n   = pending;
    clk_n    = clk_q;
    tick_n   = 1'b0;
    fall_n   = 1'b0;
    ack_n    = 1'b0;

    if (restart) begin
      cnt_n  = '0;
      clk_n  = 1'b1;
      tick_n = 1'b1;
      if (pending) begin
        d_n    = shadow;
        ack_n  = 1'b1;
        pend_n = 1'b0;
      end
    end else if (bus.en) begin
      cnt_n = cnt_inc;
      if (cnt_inc == half) begin
        clk_n  = 1'b0;
        fall_n = 1'b1;
      end
    end

    // Capture only sees the old pending flag, so a request landing on a
    // boundary edge waits for the following boundary.
    if (bus.div_req && !pending && !ack_q) begin
      shadow_n = req_div;
      pend_n   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= CNT_W'(DIV_RESET - 1);
      d       <= CNT_W'(DIV_RESET);
      shadow  <= '0;
      pending <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      fall_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      d       <= d_n;
      shadow  <= shadow_n;
      pending <= pend_n;
      clk_q   <= clk_n;
      tick_q  <= tick_n;
      fall_q  <= fall_n;
      ack_q   <= ack_n;
    end
  end

  assign bus.div_ack   = ack_q;
  assign bus.div_cur   = d;
  assign bus.div_clk   = clk_q;
  assign bus.tick      = tick_q;
  assign bus.tick_fall = fall_q;

endmodule
